// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO accumulator file.
// Holds the MAC FSM state encoding, the mac_op encodings and the
// default geometry of the file.
package hilo_pkg;

    // MAC engine sequencing: accept, multiply, accumulate-and-commit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2
    } mac_state_t;

    // mac_op encodings.
    localparam logic MAC_ADD = 1'b0;
    localparam logic MAC_SUB = 1'b1;

    // Default geometry: 32-bit halves, four accumulator pairs.
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_NUM_ACC = 4;

endpackage

// File: rtl/hilo_mac_engine.sv
// Two-cycle multiply-accumulate engine for MADD/MSUB-class instructions.
// IDLE latches the request, MUL registers the 2*WIDTH product, and ADD
// combines it with the target accumulator value supplied by the file
// and raises the commit for one cycle. While 'hold' is high the engine
// waits in MUL, so a write to its target lands before the accumulate.
module hilo_mac_engine
    import hilo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mac_valid,
    output logic               mac_ready,
    input  logic               mac_op,
    input  logic               mac_signed,
    input  logic [AW-1:0]      mac_acc,
    input  logic [WIDTH-1:0]   mac_a,
    input  logic [WIDTH-1:0]   mac_b,
    input  logic               hold,
    input  logic [2*WIDTH-1:0] acc_val,
    output logic               busy,
    output logic [AW-1:0]      busy_acc,
    output logic               commit_en,
    output logic [2*WIDTH-1:0] commit_val,
    output logic               mac_done
);

    mac_state_t         state;
    logic               op_q;
    logic               signed_q;
    logic [AW-1:0]      acc_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;

    // Extend the operands to 2*WIDTH so one truncated multiply serves
    // both the signed and the unsigned product.
    assign ext_a = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b = signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};

    // Sequencer with registered handshake outputs; mac_done marks the ADD cycle.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (!rst) begin
            state     <= IDLE;
            mac_ready <= 1'b1;
            mac_done  <= 1'b0;
            op_q      <= MAC_ADD;
            signed_q  <= 1'b0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            prod_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mac_valid) begin
                        op_q      <= mac_op;
                        signed_q  <= mac_signed;
                        acc_q     <= mac_acc;
                        a_q       <= mac_a;
                        b_q       <= mac_b;
                        mac_ready <= 1'b0;
                        state     <= MUL;
                    end
                end
                MUL: begin
                    prod_q <= ext_a * ext_b;
                    if (!hold) begin
                        mac_done <= 1'b1;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    mac_done  <= 1'b0;
                    mac_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    mac_done  <= 1'b0;
                    mac_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign busy       = ~mac_ready;
    assign busy_acc   = acc_q;
    assign commit_en  = mac_done;
    assign commit_val = (op_q == MAC_SUB) ? (acc_val - prod_q) : (acc_val + prod_q);

endmodule

// File: rtl/hilo_acc_file.sv
// HI/LO accumulator file: NUM_ACC pairs of WIDTH-bit HI/LO registers
// with an EX read port, WB write port and a MADD/MSUB engine.
// Build option: define HILO_FWD_EN to forward MEM/WB writes into the
// read port and the accumulate operand; without it the file returns
// stored values and stalls EX (and the engine) on pending writes.
module hilo_acc_file
    import hilo_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_ACC = DEF_NUM_ACC,
    parameter int AW      = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rd_acc,
    output logic [WIDTH-1:0] rd_hi,
    output logic [WIDTH-1:0] rd_lo,
    input  logic             mem_we_hi,
    input  logic             mem_we_lo,
    input  logic [AW-1:0]    mem_acc,
    input  logic [WIDTH-1:0] mem_hi,
    input  logic [WIDTH-1:0] mem_lo,
    input  logic             wb_we_hi,
    input  logic             wb_we_lo,
    input  logic [AW-1:0]    wb_acc,
    input  logic [WIDTH-1:0] wb_hi,
    input  logic [WIDTH-1:0] wb_lo,
    input  logic             mac_valid,
    output logic             mac_ready,
    input  logic             mac_op,
    input  logic             mac_signed,
    input  logic [AW-1:0]    mac_acc,
    input  logic [WIDTH-1:0] mac_a,
    input  logic [WIDTH-1:0] mac_b,
    output logic             mac_done,
    output logic             stall_req
);

    logic [WIDTH-1:0]   hi [NUM_ACC];
    logic [WIDTH-1:0]   lo [NUM_ACC];
    logic               busy;
    logic [AW-1:0]      busy_acc;
    logic               commit_en;
    logic [2*WIDTH-1:0] commit_val;
    logic [2*WIDTH-1:0] acc_val;
    logic               mac_hold;
    logic               busy_hit;

    hilo_mac_engine #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .mac_valid  (mac_valid),
        .mac_ready  (mac_ready),
        .mac_op     (mac_op),
        .mac_signed (mac_signed),
        .mac_acc    (mac_acc),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .hold       (mac_hold),
        .acc_val    (acc_val),
        .busy       (busy),
        .busy_acc   (busy_acc),
        .commit_en  (commit_en),
        .commit_val (commit_val),
        .mac_done   (mac_done)
    );

    // Storage update: WB writes per half, then the MAC commit on both halves.
    always_ff @(posedge clk) begin
        // NOTE: the whole file is cleared on reset because the pipeline
        // reads HI/LO architecturally right after reset; this rules out
        // mapping it onto a RAM macro, which is fine at this size.
        if (!rst) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                hi[i] <= '0;
                lo[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ACC; i++) begin
                if (wb_we_hi && wb_acc == AW'(i)) hi[i] <= wb_hi;
                if (wb_we_lo && wb_acc == AW'(i)) lo[i] <= wb_lo;
                // NOTE: the last non-blocking assignment in the block wins,
                // so the MAC commit overrides a same-cycle WB write here.
                if (commit_en && busy_acc == AW'(i)) begin
                    hi[i] <= commit_val[2*WIDTH-1:WIDTH];
                    lo[i] <= commit_val[WIDTH-1:0];
                end
            end
        end
    end

    // EX read port: MEM pending write beats WB write beats stored value.
    always_comb begin
        // NOTE: outputs get a full default first so no path infers a latch.
        rd_hi = hi[rd_acc];
        rd_lo = lo[rd_acc];
`ifdef HILO_FWD_EN
        if (wb_we_hi && wb_acc == rd_acc)   rd_hi = wb_hi;
        if (wb_we_lo && wb_acc == rd_acc)   rd_lo = wb_lo;
        if (mem_we_hi && mem_acc == rd_acc) rd_hi = mem_hi;
        if (mem_we_lo && mem_acc == rd_acc) rd_lo = mem_lo;
`endif
    end

    // Accumulate operand for the engine's target, WB-forwarded when enabled.
    always_comb begin
        acc_val = {hi[busy_acc], lo[busy_acc]};
`ifdef HILO_FWD_EN
        if (wb_we_hi && wb_acc == busy_acc) acc_val[2*WIDTH-1:WIDTH] = wb_hi;
        if (wb_we_lo && wb_acc == busy_acc) acc_val[WIDTH-1:0]       = wb_lo;
`endif
    end

    assign busy_hit = busy && (rd_acc == busy_acc);

`ifdef HILO_FWD_EN
    assign mac_hold  = 1'b0;
    assign stall_req = busy_hit;
`else
    // Without forwarding, hold the engine until a WB write to its target
    // has landed, and stall EX while its source has a pending write.
    assign mac_hold  = busy && (wb_we_hi || wb_we_lo) && (wb_acc == busy_acc);
    assign stall_req = busy_hit
                     || ((mem_we_hi || mem_we_lo) && (mem_acc == rd_acc))
                     || ((wb_we_hi || wb_we_lo) && (wb_acc == rd_acc));

    logic unused_mem_data;
    assign unused_mem_data = ^{mem_hi, mem_lo};
`endif

endmodule

// File: tb/tb_hilo_acc_file.sv
// Directed bench for hilo_acc_file: a table of read/write vectors plus
// hand-written MADD/MSUB, hold and mid-operation reset sequences.
// Expectations follow the HILO_FWD_EN build option.
module tb_hilo_acc_file;
    import hilo_pkg::*;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int AW = 2;
`ifdef HILO_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rd_acc;
    logic [W-1:0]  rd_hi, rd_lo;
    logic          mem_we_hi, mem_we_lo;
    logic [AW-1:0] mem_acc;
    logic [W-1:0]  mem_hi, mem_lo;
    logic          wb_we_hi, wb_we_lo;
    logic [AW-1:0] wb_acc;
    logic [W-1:0]  wb_hi, wb_lo;
    logic          mac_valid, mac_ready, mac_op, mac_signed;
    logic [AW-1:0] mac_acc;
    logic [W-1:0]  mac_a, mac_b;
    logic          mac_done, stall_req;

    always #5 clk = ~clk;

    hilo_acc_file #(.WIDTH(W), .NUM_ACC(N)) dut (
        .clk(clk), .rst(rst), .rd_acc(rd_acc), .rd_hi(rd_hi), .rd_lo(rd_lo),
        .mem_we_hi(mem_we_hi), .mem_we_lo(mem_we_lo), .mem_acc(mem_acc),
        .mem_hi(mem_hi), .mem_lo(mem_lo),
        .wb_we_hi(wb_we_hi), .wb_we_lo(wb_we_lo), .wb_acc(wb_acc),
        .wb_hi(wb_hi), .wb_lo(wb_lo),
        .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_op(mac_op),
        .mac_signed(mac_signed), .mac_acc(mac_acc), .mac_a(mac_a), .mac_b(mac_b),
        .mac_done(mac_done), .stall_req(stall_req)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] rd;
        logic          mwh, mwl;
        logic [AW-1:0] macc;
        logic [W-1:0]  mhi, mlo;
        logic          wwh, wwl;
        logic [AW-1:0] wacc;
        logic [W-1:0]  whi, wlo;
        logic [W-1:0]  exp_hi, exp_lo;
        logic          exp_stall;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(
        input logic [AW-1:0] rd,
        input logic mwh, input logic mwl, input logic [AW-1:0] macc,
        input logic [W-1:0] mhi, input logic [W-1:0] mlo,
        input logic wwh, input logic wwl, input logic [AW-1:0] wacc,
        input logic [W-1:0] whi, input logic [W-1:0] wlo,
        input logic [W-1:0] eh, input logic [W-1:0] el, input logic es);
        vec_t v;
        v.rd = rd; v.mwh = mwh; v.mwl = mwl; v.macc = macc; v.mhi = mhi; v.mlo = mlo;
        v.wwh = wwh; v.wwl = wwl; v.wacc = wacc; v.whi = whi; v.wlo = wlo;
        v.exp_hi = eh; v.exp_lo = el; v.exp_stall = es;
        return v;
    endfunction

    task automatic idle_inputs();
        rd_acc = '0;
        mem_we_hi = 1'b0; mem_we_lo = 1'b0; mem_acc = '0; mem_hi = '0; mem_lo = '0;
        wb_we_hi = 1'b0; wb_we_lo = 1'b0; wb_acc = '0; wb_hi = '0; wb_lo = '0;
        mac_valid = 1'b0; mac_op = MAC_ADD; mac_signed = 1'b0; mac_acc = '0;
        mac_a = '0; mac_b = '0;
    endtask

    task automatic issue(input logic op, input logic sgn, input logic [AW-1:0] acc,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        mac_valid = 1'b1; mac_op = op; mac_signed = sgn; mac_acc = acc;
        mac_a = a; mac_b = b;
    endtask

    initial begin
        int k;
        // Vectors run back to back; each one's writes land before the next.
        vecs[0]  = mk(0, 0,0,0, 0,0,                       0,0,0, 0,0,
                      32'h0, 32'h0, 1'b0);
        vecs[1]  = mk(1, 0,0,0, 0,0,                       1,0,1, 32'hFFFF0000, 32'h0,
                      FWD ? 32'hFFFF0000 : 32'h0, 32'h0, !FWD);
        vecs[2]  = mk(1, 0,0,0, 0,0,                       0,0,0, 0,0,
                      32'hFFFF0000, 32'h0, 1'b0);
        vecs[3]  = mk(1, 1,0,1, 32'h05050000,0,            1,0,1, 32'hFFFF0000, 32'h0,
                      FWD ? 32'h05050000 : 32'hFFFF0000, 32'h0, !FWD);
        vecs[4]  = mk(1, 0,1,1, 32'h99990000,32'h0000AAAA, 1,0,1, 32'h11112222, 32'h77777777,
                      FWD ? 32'h11112222 : 32'hFFFF0000, FWD ? 32'h0000AAAA : 32'h0, !FWD);
        vecs[5]  = mk(1, 0,0,0, 0,0,                       0,0,0, 0,0,
                      32'h11112222, 32'h0, 1'b0);
        vecs[6]  = mk(0, 0,0,0, 0,0,                       0,1,1, 32'h33333333, 32'h5,
                      32'h0, 32'h0, 1'b0);
        vecs[7]  = mk(1, 0,0,0, 0,0,                       0,0,0, 0,0,
                      32'h11112222, 32'h5, 1'b0);
        vecs[8]  = mk(2, 0,0,0, 0,0,                       1,1,2, 32'h0, 32'h5,
                      32'h0, FWD ? 32'h5 : 32'h0, !FWD);
        vecs[9]  = mk(2, 0,0,0, 0,0,                       0,0,0, 0,0,
                      32'h0, 32'h5, 1'b0);
        vecs[10] = mk(3, 1,1,3, 32'hDEAD0000,32'h0000BEEF, 0,0,0, 0,0,
                      FWD ? 32'hDEAD0000 : 32'h0, FWD ? 32'h0000BEEF : 32'h0, !FWD);
        vecs[11] = mk(3, 0,0,0, 0,0,                       0,0,0, 0,0,
                      32'h0, 32'h0, 1'b0);

        // Reset held for four cycles, then every accumulator reads zero.
        idle_inputs();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            rd_acc = AW'(i);
            #1;
            check($sformatf("rst_hi%0d", i), rd_hi, 32'h0);
            check($sformatf("rst_lo%0d", i), rd_lo, 32'h0);
        end
        check("rst_ready", {31'b0, mac_ready}, 32'h1);
        check("rst_done",  {31'b0, mac_done},  32'h0);
        check("rst_stall", {31'b0, stall_req}, 32'h0);

        // Table-driven read/write/forwarding vectors.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            idle_inputs();
            rd_acc = vecs[i].rd;
            mem_we_hi = vecs[i].mwh; mem_we_lo = vecs[i].mwl; mem_acc = vecs[i].macc;
            mem_hi = vecs[i].mhi; mem_lo = vecs[i].mlo;
            wb_we_hi = vecs[i].wwh; wb_we_lo = vecs[i].wwl; wb_acc = vecs[i].wacc;
            wb_hi = vecs[i].whi; wb_lo = vecs[i].wlo;
            #1;
            check($sformatf("v%0d_hi", i), rd_hi, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), rd_lo, vecs[i].exp_lo);
            check($sformatf("v%0d_stall", i), {31'b0, stall_req}, {31'b0, vecs[i].exp_stall});
        end

        // Signed MADD: acc2 = {0,5} + 3 * -1 = {0,2}.
        @(negedge clk); idle_inputs();
        issue(MAC_ADD, 1'b1, 2, 32'd3, 32'hFFFFFFFF);
        rd_acc = 2;
        #1 check("madd_ready", {31'b0, mac_ready}, 32'h1);
        @(negedge clk); mac_valid = 1'b0;
        #1 check("madd_mul_ready", {31'b0, mac_ready}, 32'h0);
        check("madd_mul_done",  {31'b0, mac_done},  32'h0);
        check("madd_mul_stall", {31'b0, stall_req}, 32'h1);
        @(negedge clk);
        #1 check("madd_add_done", {31'b0, mac_done},  32'h1);
        check("madd_add_stall",   {31'b0, stall_req}, 32'h1);
        @(negedge clk);
        #1 check("madd_post_done", {31'b0, mac_done}, 32'h0);
        check("madd_post_ready", {31'b0, mac_ready}, 32'h1);
        check("madd_hi", rd_hi, 32'h00000000);
        check("madd_lo", rd_lo, 32'h00000002);

        // Unsigned MSUB: acc3 = 0 - 2 * 0x80000000 = {FFFFFFFF,00000000}.
        @(negedge clk); idle_inputs();
        issue(MAC_SUB, 1'b0, 3, 32'd2, 32'h80000000);
        @(negedge clk); mac_valid = 1'b0; rd_acc = 3;
        #1 check("msub_mul_stall3", {31'b0, stall_req}, 32'h1);
        @(negedge clk); rd_acc = 0;
        #1 check("msub_add_stall0", {31'b0, stall_req}, 32'h0);
        check("msub_add_done", {31'b0, mac_done}, 32'h1);
        @(negedge clk); rd_acc = 3;
        #1 check("msub_hi", rd_hi, 32'hFFFFFFFF);
        check("msub_lo", rd_lo, 32'h00000000);

        // WB write to the engine's target during MUL: acc0 = {0,0x10} + 1*1.
        @(negedge clk); idle_inputs();
        issue(MAC_ADD, 1'b0, 0, 32'd1, 32'd1);
        rd_acc = 1;
        @(negedge clk); mac_valid = 1'b0;
        wb_we_lo = 1'b1; wb_acc = 0; wb_lo = 32'h10;
        #1 check("hold_mul_done", {31'b0, mac_done}, 32'h0);
        @(negedge clk); wb_we_lo = 1'b0; wb_lo = '0;
        #1 check("hold_next_done", {31'b0, mac_done}, {31'b0, FWD});
        k = 0;
        while (!mac_done && k < 4) begin
            @(negedge clk);
            #1 k++;
        end
        check("hold_done_seen", {31'b0, mac_done}, 32'h1);
        @(negedge clk); rd_acc = 0;
        #1 check("hold_hi", rd_hi, 32'h0);
        check("hold_lo", rd_lo, 32'h11);

        // Reset during MUL of a MADD to acc1: no commit, file cleared.
        @(negedge clk); idle_inputs();
        issue(MAC_ADD, 1'b0, 1, 32'd5, 32'd5);
        @(negedge clk); mac_valid = 1'b0; rst = 1'b0;
        #1 check("rmid_mul_done", {31'b0, mac_done}, 32'h0);
        @(negedge clk);
        #1 check("rmid_rst_done", {31'b0, mac_done}, 32'h0);
        @(negedge clk); rst = 1'b1; rd_acc = 1;
        #1 check("rmid_hi", rd_hi, 32'h0);
        check("rmid_lo", rd_lo, 32'h0);
        check("rmid_ready", {31'b0, mac_ready}, 32'h1);
        check("rmid_stall", {31'b0, stall_req}, 32'h0);
        @(negedge clk);
        #1 check("rmid_after_done", {31'b0, mac_done}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
